// File: rtl/bcd_tick_counter_if.sv
// Bus bundle for bcd_tick_counter: control inputs plus packed BCD digits,
// per-digit enables and status flags.
interface bcd_tick_counter_if #(
   parameter int DIGITS = 2
);
   logic                  start;
   logic                  clear;
   logic                  up_dn;
   logic [4*DIGITS-1:0]   bcd;
   logic [DIGITS-1:0]     digit_en;
   logic                  running;
   logic                  wrap;

   modport master (
      output start, clear, up_dn,
      input  bcd, digit_en, running, wrap
   );

   modport slave (
      input  start, clear, up_dn,
      output bcd, digit_en, running, wrap
   );
endinterface

// File: rtl/bcd_tick_counter.sv
// Multi-digit BCD up/down tick counter with prescaler, RUN/IDLE toggle,
// synchronous clear, wrap pulse and leading-zero blanking enables.

// One decade of the ripple chain: pure combinational step of a single digit.
module bcd_digit (
   input  logic [3:0] d,
   input  logic       up,
   input  logic       cin,
   output logic [3:0] q,
   output logic       cout
);
   // increment/decrement when the lower decade carries/borrows in
   always_comb begin
      q    = d;
      cout = 1'b0;
      if (cin) begin
         if (up) begin
            // anything at or above 9 (including forced non-BCD) rolls to 0
            if (d >= 4'd9) begin
               q    = 4'd0;
               cout = 1'b1;
            end else begin
               q = d + 4'd1;
            end
         end else begin
            if (d == 4'd0) begin
               q    = 4'd9;
               cout = 1'b1;
            end else begin
               q = d - 4'd1;
            end
         end
      end
   end
endmodule

module bcd_tick_counter #(
   parameter int          DIGITS   = 2,
   parameter int unsigned PRESCALE = 50000000,
   parameter int          PW       = 32
) (
   input  logic             clk,
   input  logic             rst,
   bcd_tick_counter_if.slave bus
);
   localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                  state, state_nxt;
   logic                    run_act;
   logic                    start_q, armed, start_edge;
   logic [PW-1:0]           psc;
   logic                    tick;
   logic [DIGITS-1:0][3:0]  dig, dig_nxt;
   logic [DIGITS:0]         cy;
   logic                    wrap_q;
   logic [DIGITS-1:0]       en;
   logic                    nz;

   // Edge detect needs two post-reset samples: a start level held through
   // reset is only loaded into start_q and never seen as a rising edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_q <= 1'b0;
         armed   <= 1'b0;
      end else begin
         start_q <= bus.start;
         armed   <= 1'b1;
      end
   end

   assign start_edge = armed & bus.start & ~start_q;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // start edge toggles RUN/IDLE; clear has no effect on state
   always_comb begin
      state_nxt = state;
      run_act   = 1'b0;
      if (state == RUN) run_act = 1'b1;
      if (start_edge) state_nxt = (state == RUN) ? IDLE : RUN;
   end

   // tick only from RUN, so an IDLE->RUN edge never ticks in its own cycle
   assign tick = run_act & (psc == PS_LAST) & ~bus.clear;

   // prescaler counts in RUN, holds in IDLE so a pause keeps the partial period
   always_ff @(posedge clk or posedge rst) begin
      if (rst)              psc <= '0;
      else if (bus.clear)   psc <= '0;
      else if (run_act)     psc <= (psc == PS_LAST) ? '0 : psc + 1'b1;
   end

   assign cy[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_dig
         bcd_digit u_dig (
            .d    (dig[gi]),
            .up   (bus.up_dn),
            .cin  (cy[gi]),
            .q    (dig_nxt[gi]),
            .cout (cy[gi+1])
         );
      end
   endgenerate

   // digit registers and wrap pulse: clear > tick > hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dig    <= '0;
         wrap_q <= 1'b0;
      end else if (bus.clear) begin
         dig    <= '0;
         wrap_q <= 1'b0;
      end else if (tick) begin
         dig    <= dig_nxt;
         wrap_q <= cy[DIGITS];
      end else begin
         wrap_q <= 1'b0;
      end
   end

   // leading-zero blanking: digit i lit if it or any higher digit is non-zero
   always_comb begin
      en    = '0;
      nz    = 1'b0;
      en[0] = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         nz    = nz | (dig[i] != 4'd0);
         en[i] = nz;
      end
   end

   assign bus.bcd      = dig;
   assign bus.digit_en = en;
   assign bus.running  = (state == RUN);
   assign bus.wrap     = wrap_q;
endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed bench for bcd_tick_counter (DIGITS=2, PRESCALE=4) with a
// decimal-integer reference model feeding an expected-value queue.
module tb_bcd_tick_counter;
   localparam int DIGITS = 2;
   localparam int P      = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bcd_tick_counter_if #(.DIGITS(DIGITS)) bus ();

   bcd_tick_counter #(.DIGITS(DIGITS), .PRESCALE(P), .PW(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [7:0] bcd;
      logic [1:0] en;
      logic       run;
      logic       wrap;
   } exp_t;

   exp_t sbq[$];
   int   tests = 0;
   int   fails = 0;

   // reference model state: counter value as a plain integer 0..99
   int   m_val, m_psc;
   bit   m_run, m_wrap, m_sq, m_armed;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_val = 0; m_psc = 0; m_run = 0; m_wrap = 0; m_sq = 0; m_armed = 0;
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.bcd  = {4'(m_val / 10), 4'(m_val % 10)};
      e.en   = (m_val >= 10) ? 2'b11 : 2'b01;
      e.run  = m_run;
      e.wrap = m_wrap;
      return e;
   endfunction

   // advance model with current inputs, queue expectation, clock DUT, compare
   task automatic cyc();
      bit   edg, tk;
      exp_t e;
      edg    = m_armed && bus.start && !m_sq;
      tk     = m_run && (m_psc == P - 1) && !bus.clear;
      m_wrap = tk && (bus.up_dn ? (m_val == 99) : (m_val == 0));
      if (bus.clear)  m_val = 0;
      else if (tk)    m_val = bus.up_dn ? (m_val + 1) % 100 : (m_val + 99) % 100;
      if (bus.clear)  m_psc = 0;
      else if (m_run) m_psc = (m_psc == P - 1) ? 0 : m_psc + 1;
      if (edg) m_run = !m_run;
      m_sq    = bus.start;
      m_armed = 1;
      sbq.push_back(model_out());
      @(posedge clk); #1;
      e = sbq.pop_front();
      chk("cyc.bcd",  bus.bcd,      e.bcd);
      chk("cyc.en",   bus.digit_en, e.en);
      chk("cyc.run",  bus.running,  e.run);
      chk("cyc.wrap", bus.wrap,     e.wrap);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".bcd"},  bus.bcd,      8'h00);
      chk({tag, ".en"},   bus.digit_en, 2'b01);
      chk({tag, ".run"},  bus.running,  1'b0);
      chk({tag, ".wrap"}, bus.wrap,     1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, k;
      rst = 1'b1; bus.start = 1'b1; bus.clear = 1'b0; bus.up_dn = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("in_reset");
      rst = 1'b0;

      // start held high through reset must not start the counter
      repeat (5) cyc();
      chk("held_start.run", bus.running, 1'b0);
      bus.start = 1'b0;
      repeat (2) cyc();

      // start pulse, count up to 10
      bus.start = 1'b1; cyc(); bus.start = 1'b0;
      chk("start.run", bus.running, 1'b1);
      repeat (39) cyc();
      chk("at09.bcd", bus.bcd, 8'h09);
      chk("at09.en",  bus.digit_en, 2'b01);
      cyc();
      chk("at10.bcd", bus.bcd, 8'h10);
      chk("at10.en",  bus.digit_en, 2'b11);

      // up to 99 then wrap to 00
      n = 0;
      while (m_val != 99 && n < 1000) begin cyc(); n++; end
      chk("reach99.bcd", bus.bcd, 8'h99);
      n = 0;
      while (m_val != 0 && n < 10) begin cyc(); n++; end
      chk("upwrap.bcd",  bus.bcd, 8'h00);
      chk("upwrap.wrap", bus.wrap, 1'b1);
      chk("upwrap.en",   bus.digit_en, 2'b01);
      cyc();
      chk("upwrap.pulse1", bus.wrap, 1'b0);

      // count down: 00 -> 99 with wrap, then 98 without
      bus.up_dn = 1'b0;
      n = 0;
      while (m_val != 99 && n < 10) begin cyc(); n++; end
      chk("dnwrap.bcd",  bus.bcd, 8'h99);
      chk("dnwrap.wrap", bus.wrap, 1'b1);
      n = 0;
      while (m_val != 98 && n < 10) begin cyc(); n++; end
      chk("dn98.bcd",  bus.bcd, 8'h98);
      chk("dn98.wrap", bus.wrap, 1'b0);

      // clear, count to 37, pause mid-period, resume
      bus.up_dn = 1'b1;
      bus.clear = 1'b1; cyc(); bus.clear = 1'b0;
      chk("clr.bcd", bus.bcd, 8'h00);
      chk("clr.run", bus.running, 1'b1);
      n = 0;
      while (m_val != 37 && n < 400) begin cyc(); n++; end
      repeat (2) cyc();
      bus.start = 1'b1; cyc(); bus.start = 1'b0;
      chk("pause.run", bus.running, 1'b0);
      k = m_psc;
      repeat (20) cyc();
      chk("pause.hold", bus.bcd, 8'h37);
      bus.start = 1'b1; cyc(); bus.start = 1'b0;
      chk("resume.run", bus.running, 1'b1);
      n = 0;
      while (bus.bcd == 8'h37 && n < 10) begin cyc(); n++; end
      chk("resume.lat", n, P - k);
      chk("resume.bcd", bus.bcd, 8'h38);

      // clear on the exact tick cycle at 45
      n = 0;
      while (!(m_val == 45 && m_psc == P - 1) && n < 400) begin cyc(); n++; end
      chk("pre_clr.bcd", bus.bcd, 8'h45);
      bus.clear = 1'b1; cyc(); bus.clear = 1'b0;
      chk("tickclr.bcd",  bus.bcd, 8'h00);
      chk("tickclr.wrap", bus.wrap, 1'b0);
      chk("tickclr.run",  bus.running, 1'b1);

      // async reset mid-period, no clock edge needed
      repeat (6) cyc();
      chk("pre_rst.bcd", bus.bcd, 8'h01);
      #3 rst = 1'b1;
      #1 chk_reset_vals("async_rst");
      model_reset();
      #2 rst = 1'b0;
      repeat (3) cyc();
      chk("post_rst.run", bus.running, 1'b0);
      bus.start = 1'b1; cyc(); bus.start = 1'b0;
      repeat (4) cyc();
      chk("post_rst.bcd", bus.bcd, 8'h01);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
